// File: rtl/vec_acc_ctrl.sv
// Vector accumulation sequencer: drives the external 16-lane adder and folds cfg_len input vectors into acc.
// Optional per-lane sticky signed-overflow flags when VEC_ACC_OVF_FLAG_EN is defined.

module vec_acc_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          acc_clr,
    input  logic          acc_ld,
    input  logic [DW-1:0] s,
    output logic [DW-1:0] acc
`ifdef VEC_ACC_OVF_FLAG_EN
    ,
    input  logic [DW-1:0] b,
    input  logic          ovf_clr,
    output logic          ovf
`endif
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (acc_ld)  acc <= s;
    end

`ifdef VEC_ACC_OVF_FLAG_EN
    // acc is operand A, so the sign rule reads it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (ovf_clr) ovf <= 1'b0;
        else if (acc_ld && (acc[DW-1] == b[DW-1]) && (s[DW-1] != acc[DW-1]))
            ovf <= 1'b1;
    end
`endif
endmodule

module vec_acc_ctrl #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                clear,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANES*DW-1:0] add0,
    output logic [LANES*DW-1:0] add1,
    input  logic [LANES*DW-1:0] sum,
    output logic [LANES*DW-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
`ifdef VEC_ACC_OVF_FLAG_EN
    ,
    output logic [LANES-1:0]    ovf
`endif
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                   state, state_nx;
    logic [LEN_W-1:0]         cnt, len_q;
    logic [LANES-1:0][DW-1:0] acc;
    logic                     start_acc, hs, last;

    assign start_acc = (state == IDLE) && start && !clear;
    assign hs        = (state == ACC) && in_valid && !clear;
    assign last      = hs && (cnt == len_q - LEN_W'(1));

    assign add0     = acc;
    assign add1     = in_data;
    assign out_data = acc;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: if (start_acc) state_nx = (cfg_len != '0) ? ACC : DONE;
            ACC: begin
                in_ready = !clear;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    // cnt never exceeds len_q, so a full-range cfg_len cannot wrap it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start_acc) begin
            cnt   <= '0;
            len_q <= cfg_len;
        end else if (hs) begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vec_acc_lane #(.DW(DW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .acc_clr (start_acc),
            .acc_ld  (hs),
            .s       (sum[i*DW +: DW]),
            .acc     (acc[i])
`ifdef VEC_ACC_OVF_FLAG_EN
            ,
            .b       (in_data[i*DW +: DW]),
            .ovf_clr (start_acc || clear),
            .ovf     (ovf[i])
`endif
        );
    end
endmodule

// File: tb/tb_vec_acc_ctrl.sv
// Bench for vec_acc_ctrl: table vectors, randomized runs against a lane-sum model, clear/reset sequences.
module tb_vec_acc_ctrl;
    localparam int LANES = 16, DW = 16, LEN_W = 8, W = LANES*DW;
    typedef logic [W-1:0] vec_t;
    typedef struct {
        int          len;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp0;
    } vec_rec_t;

    logic             clk = 0, rst_n = 0, start = 0, clear = 0, in_valid = 0, out_ready = 0;
    logic [LEN_W-1:0] cfg_len = '0;
    vec_t             in_data = '0, add0, add1, sum, out_data;
    logic             in_ready, out_valid, busy;
`ifdef VEC_ACC_OVF_FLAG_EN
    logic [LANES-1:0] ovf;
`endif

    int   errors = 0, checks = 0;
    vec_t beat_q[$];

    always #5 clk = ~clk;

    // the shared adder lives outside the block
    for (genvar g = 0; g < LANES; g++) begin : g_add
        assign sum[g*DW +: DW] = add0[g*DW +: DW] + add1[g*DW +: DW];
    end

    vec_acc_ctrl #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add0(add0), .add1(add1), .sum(sum),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef VEC_ACC_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Reference: per-lane signed integer sums, truncated to DW; overflow when a partial sum leaves the DW range
    task automatic model(output vec_t r, output logic [LANES-1:0] o);
        r = '0;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            int tot = 0;
            foreach (beat_q[k]) begin
                logic [DW-1:0] bv;
                int            nx;
                bv = beat_q[k][i*DW +: DW];
                nx = tot + int'($signed(bv));
                if (nx > 32767 || nx < -32768) o[i] = 1'b1;
                tot = int'($signed(DW'(nx)));
            end
            r[i*DW +: DW] = DW'(tot);
        end
    endtask

    task automatic run(input string name, input int len, input int gap, input int hold,
                       input logic [15:0] exp0, input bit use_exp0);
        vec_t             exp_v;
        logic [LANES-1:0] exp_o;
        int               n, cyc;
        bit               early, rdy_bad, unstable;
        model(exp_v, exp_o);
        start   = 1;
        cfg_len = LEN_W'(len);
        @(negedge clk);
        start   = 0;
        cfg_len = LEN_W'($urandom);
        chk({name, " busy_after_start"}, vec_t'(busy), vec_t'(1));
        n = 0; cyc = 0; early = 0; rdy_bad = 0;
        while (n < len && cyc < 4000) begin
            in_valid = ($urandom_range(0, 99) >= gap);
            in_data  = in_valid ? beat_q[n] : rand_vec();
            start    = 1'($urandom_range(0, 1));
            cfg_len  = LEN_W'($urandom);
            if (!in_ready) rdy_bad = 1;
            if (out_valid) early = 1;
            @(negedge clk);
            if (in_valid) n++;
            cyc++;
        end
        in_valid = 0;
        start    = 0;
        chk({name, " beats_taken"}, vec_t'(n), vec_t'(len));
        chk({name, " in_ready_bad_in_acc"}, vec_t'(rdy_bad), vec_t'(0));
        chk({name, " out_valid_early"}, vec_t'(early), vec_t'(0));
        chk({name, " out_valid"}, vec_t'(out_valid), vec_t'(1));
        chk({name, " in_ready_done"}, vec_t'(in_ready), vec_t'(0));
        chk({name, " busy_done"}, vec_t'(busy), vec_t'(1));
        chk({name, " out_data"}, out_data, exp_v);
        if (use_exp0) chk({name, " lane0"}, vec_t'(out_data[DW-1:0]), vec_t'(exp0));
`ifdef VEC_ACC_OVF_FLAG_EN
        chk({name, " ovf"}, vec_t'(ovf), vec_t'(exp_o));
`endif
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_data !== exp_v || !busy) unstable = 1;
        end
        if (hold > 0) chk({name, " done_stable"}, vec_t'(unstable), vec_t'(0));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({name, " idle_out_valid"}, vec_t'(out_valid), vec_t'(0));
        chk({name, " idle_busy"}, vec_t'(busy), vec_t'(0));
        chk({name, " acc_retained"}, out_data, exp_v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_rec_t tbl[6];
        vec_t     b1, v;
        bit       bad;
        tbl[0] = '{3, 16'h0001, 16'h0001, 16'h0006};
        tbl[1] = '{1, 16'h0010, 16'h0000, 16'h0010};
        tbl[2] = '{2, 16'h7FFF, 16'h8002, 16'h8000};
        tbl[3] = '{0, 16'h1234, 16'h0000, 16'h0000};
        tbl[4] = '{4, 16'hFFFF, 16'h0000, 16'hFFFC};
        tbl[5] = '{5, 16'd100,  16'd10,   16'h0258};

        #3;
        chk("reset in_ready", vec_t'(in_ready), vec_t'(0));
        chk("reset out_valid", vec_t'(out_valid), vec_t'(0));
        chk("reset busy", vec_t'(busy), vec_t'(0));
        chk("reset out_data", out_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            beat_q.delete();
            for (int k = 0; k < tbl[t].len; k++) begin
                for (int i = 0; i < LANES; i++)
                    v[i*DW +: DW] = tbl[t].a + 16'(k) * tbl[t].b + 16'(i);
                beat_q.push_back(v);
            end
            run($sformatf("tbl%0d", t), tbl[t].len, 0, (t == 0) ? 3 : 0, tbl[t].exp0, 1);
        end

        for (int r = 0; r < 16; r++) begin
            int len;
            len = (r == 0) ? 4 : $urandom_range(1, 10);
            beat_q.delete();
            for (int k = 0; k < len; k++) beat_q.push_back(rand_vec());
            run($sformatf("rnd%0d", r), len, (r == 0) ? 50 : $urandom_range(0, 60),
                (r == 0) ? 5 : $urandom_range(0, 4), 16'h0, 0);
        end

        beat_q.delete();
        for (int k = 0; k < 255; k++) beat_q.push_back(rand_vec());
        run("len255", 255, 0, 0, 16'h0, 0);

        // clear together with start and a valid beat mid-run
        b1 = rand_vec();
        start = 1; cfg_len = 5;
        @(negedge clk);
        start = 0; in_valid = 1; in_data = b1;
        @(negedge clk);
        in_data = rand_vec(); start = 1; clear = 1; cfg_len = 1;
        @(negedge clk);
        clear = 0; start = 0; in_valid = 0;
        chk("clear busy", vec_t'(busy), vec_t'(0));
        chk("clear out_valid", vec_t'(out_valid), vec_t'(0));
        chk("clear in_ready", vec_t'(in_ready), vec_t'(0));
        chk("clear acc_kept", out_data, b1);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid || busy) bad = 1;
        end
        chk("clear stays_idle", vec_t'(bad), vec_t'(0));
        beat_q.delete();
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 16'h0010;
        beat_q.push_back(v);
        run("clear_restart", 1, 0, 0, 16'h0010, 1);

        // reset mid-accumulation
        start = 1; cfg_len = 3;
        @(negedge clk);
        start = 0; in_valid = 1;
        for (int k = 0; k < 2; k++) begin
            in_data = rand_vec();
            @(negedge clk);
        end
        #2 rst_n = 0;
        #1;
        chk("midrst in_ready", vec_t'(in_ready), vec_t'(0));
        chk("midrst out_valid", vec_t'(out_valid), vec_t'(0));
        chk("midrst busy", vec_t'(busy), vec_t'(0));
        chk("midrst out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready || busy || out_valid) bad = 1;
        end
        in_valid = 0;
        chk("midrst stays_idle", vec_t'(bad), vec_t'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
